calc2_port_responder: RTL
=========================

Name: calc2_port_responder

Overview:
- Single-port request responder for the calc2 request/response protocol. It is the DUT-side end of the cmd/data/tag interface that the calc2 bench drives.
- Captures two-cycle requests (command + operand1, then operand2) and buffers them in a small FIFO.
- Executes add/sub/shift, then returns one-cycle responses on out_resp/out_data/out_tag in acceptance order.
- Used as the per-port engine of the calc2 core and as a reference responder for bench bring-up.

Parameters:
- DATA_W, 32, operand/result width
- TAG_W, 2, request tag width
- FIFO_DEPTH, 4, pending-request buffer entries (power of 2, >=2)

Ports:
- c_clk  in  1  clock, rising edge
- reset  in  1  asynchronous active-low reset
- req_cmd_in  in  4  command: 1=add, 2=sub, 5=shl, 6=shr, 0=no request
- req_data_in  in  DATA_W  operand1 in command cycle, operand2 in following cycle
- req_tag_in  in  TAG_W  request tag, sampled in command cycle
- out_resp  out  2  00=none, 01=success, 10=overflow/underflow/invalid
- out_data  out  DATA_W  result; 0 unless out_resp=01
- out_tag  out  TAG_W  tag of the response; 0 when out_resp=00
- ovf_err  out  1  sticky: a request was dropped because the FIFO was full
- dup_tag_err  out  1  sticky duplicate-tag flag (see Optional Feature)

Behaviour:
- Reset (reset=0, async): all outputs 0; FSMs to IDLE/E_IDLE; FIFO emptied; in-flight and buffered requests discarded, never answered.
- Input FSM:
  - IDLE: if req_cmd_in!=0, capture cmd, tag, data as op1, go to OP2.
  - OP2: capture req_data_in as op2 unconditionally (req_cmd_in ignored), push {cmd,tag,op1,op2}, go to IDLE.
  - Maximum acceptance rate is one request per 2 cycles.
- FIFO:
  - Push at the OP2 edge.
  - Full with no same-cycle pop: entry discarded, ovf_err<=1, no response for it.
  - Full with same-cycle pop: push accepted.
  - Empty: no pop.
  - Pointers wrap modulo FIFO_DEPTH.
- Execute FSM (one request at a time):
  - E_IDLE: if FIFO non-empty, pop, load acc=op1, cnt=op2[4:0]. Go to E_SHIFT for cmd 5/6, otherwise E_ARITH.
  - E_ARITH (1 cycle), then E_IDLE:
    - add: 33-bit sum. Carry -> resp 10, data 0; else resp 01, data sum[31:0].
    - sub: op2>op1 (unsigned) -> resp 10, data 0; else resp 01, data op1-op2.
    - Any other nonzero cmd (invalid) -> resp 10, data 0.
  - E_SHIFT:
    - cnt==0: emit resp 01, data acc, go to E_IDLE.
    - Else: acc shifts one bit (shl: <<1 zero-fill; shr: >>1 logical) and cnt decrements.
    - A shift by n occupies n+1 cycles.
- Outputs:
  - Registered. out_resp/out_data/out_tag are valid for exactly one cycle, then return to 0.
  - At most one response per cycle.
  - Responses are in push order.
- Latency (empty FIFO, idle engine, command in cycle T):
  - add/sub/invalid: response visible in cycle T+4.
  - shift by n: response visible in T+4+n.
- Arithmetic is unsigned. Shift amount uses op2[4:0] only.

Optional Feature:
- Macro CALC2_TAG_CHECK_EN.
- Defined: at the OP2 edge, if the new tag equals the tag of any valid FIFO entry or of the request in execution, the request is not pushed, dup_tag_err<=1, and no response is generated for it. The FIFO-full check still applies when tags are unique.
- Undefined: no tag comparison; duplicate tags are accepted and answered in order; dup_tag_err tied 0.

Test Plan:
1. add op1=0x10, op2=0x20, tag 1, command at T -> out_resp=01, out_data=0x30, out_tag=1 in T+4; out_resp=00 in T+5.
2. add 0xFFFFFFFF+0x1 -> resp 10, data 0. sub 5-7 -> resp 10, data 0. sub 7-5 -> resp 01, data 0x2.
3. shl op1=0x1, op2=0x23 (amount 3) at T -> resp 01, data 0x8 at T+7. shr 0x80000000 by 31 -> data 0x1.
4. Invalid cmd 4'h3, tag 2 -> resp 10, data 0, tag 2, T+4.
5. Six back-to-back shr-by-31 requests, tags 0,1,2,3,0,1, macro undefined -> five responses, tags 0,1,2,3,0, in order; sixth dropped; ovf_err=1 and stays 1.
6. reset pulsed low during a shift-by-20 with 2 requests queued -> outputs 0 immediately, no responses after release. A new add then completes at T+4. With CALC2_TAG_CHECK_EN, a second request with an outstanding tag sets dup_tag_err and receives no response.

Source files
------------

// File: rtl/calc2_port_responder.sv
// rtl/calc2_port_responder.sv - calc2 single-port request responder (capture, FIFO, execute, respond)
//
// Optional feature macro: CALC2_TAG_CHECK_EN (duplicate-tag rejection, drives dup_tag_err)
//
// Ports:
//   c_clk        in   clock, rising edge
//   reset        in   asynchronous active-low reset
//   req_cmd_in   in   command: 1=add 2=sub 5=shl 6=shr 0=none, others invalid
//   req_data_in  in   operand1 in command cycle, operand2 in the following cycle
//   req_tag_in   in   request tag, sampled in command cycle
//   out_resp     out  00=none 01=success 10=overflow/underflow/invalid (one-cycle pulse)
//   out_data     out  result, 0 unless out_resp=01
//   out_tag      out  tag of the response, 0 when out_resp=00
//   ovf_err      out  sticky: a request was dropped on a full FIFO
//   dup_tag_err  out  sticky: a request was dropped for a duplicate tag (0 without the macro)
module calc2_port_responder #(
  parameter int DATA_W     = 32,
  parameter int TAG_W      = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              c_clk,
  input  logic              reset,
  input  logic [3:0]        req_cmd_in,
  input  logic [DATA_W-1:0] req_data_in,
  input  logic [TAG_W-1:0]  req_tag_in,
  output logic [1:0]        out_resp,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic              ovf_err,
  output logic              dup_tag_err
);

  localparam int ADDR_W = $clog2(FIFO_DEPTH);

  localparam logic [3:0] CMD_ADD  = 4'd1;
  localparam logic [3:0] CMD_SUB  = 4'd2;
  localparam logic [3:0] CMD_SHL  = 4'd5;
  localparam logic [3:0] CMD_SHR  = 4'd6;
  localparam logic [1:0] RESP_OK  = 2'b01;
  localparam logic [1:0] RESP_ERR = 2'b10;

  typedef enum logic {IDLE, OP2} in_state_t;
  typedef enum logic [1:0] {E_IDLE, E_ARITH, E_SHIFT} ex_state_t;

  // Input capture
  in_state_t         in_state;
  logic [3:0]        cap_cmd;
  logic [TAG_W-1:0]  cap_tag;
  logic [DATA_W-1:0] cap_op1;

  // Pending-request FIFO
  logic [3:0]        fifo_cmd [FIFO_DEPTH];
  logic [TAG_W-1:0]  fifo_tag [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_op1 [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_op2 [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;

  // Execute engine
  ex_state_t         ex_state;
  logic [3:0]        ex_cmd;
  logic [TAG_W-1:0]  ex_tag;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] ex_op2;
  logic [4:0]        cnt;

  logic              fifo_full;
  logic              fifo_empty;
  logic              do_pop;
  logic              push_req;
  logic              dup_hit;
  logic              do_push;
  logic [DATA_W:0]   sum;
  logic [3:0]        pop_cmd;
  logic [DATA_W-1:0] pop_op2;

  assign fifo_full  = (count == (ADDR_W+1)'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign do_pop     = (ex_state == E_IDLE) && !fifo_empty;
  assign push_req   = (in_state == OP2);
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign do_push    = push_req && !dup_hit && (!fifo_full || do_pop);
  assign sum        = {1'b0, acc} + {1'b0, ex_op2};
  assign pop_cmd    = fifo_cmd[rd_ptr];
  assign pop_op2    = fifo_op2[rd_ptr];

`ifdef CALC2_TAG_CHECK_EN
  logic [ADDR_W-1:0] off;
  logic              dup_err_q;

  // Live entries are those whose distance from rd_ptr is below count.
  always_comb begin
    off     = '0;
    dup_hit = (ex_state != E_IDLE) && (ex_tag == cap_tag);
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      off = ADDR_W'(i) - rd_ptr;
      if (({1'b0, off} < count) && (fifo_tag[i] == cap_tag)) dup_hit = 1'b1;
    end
  end

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) dup_err_q <= 1'b0;
    else if (push_req && dup_hit) dup_err_q <= 1'b1;
  end

  assign dup_tag_err = dup_err_q;
`else
  assign dup_hit     = 1'b0;
  assign dup_tag_err = 1'b0;
`endif

  // Input FSM: command cycle then operand2 cycle.
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      in_state <= IDLE;
      cap_cmd  <= '0;
      cap_tag  <= '0;
      cap_op1  <= '0;
    end else begin
      case (in_state)
        IDLE: begin
          if (req_cmd_in != 4'd0) begin
            cap_cmd  <= req_cmd_in;
            cap_tag  <= req_tag_in;
            cap_op1  <= req_data_in;
            in_state <= OP2;
          end
        end
        default: in_state <= IDLE;
      endcase
    end
  end

  // FIFO storage carries no reset; validity comes from count.
  always_ff @(posedge c_clk) begin
    if (do_push) begin
      fifo_cmd[wr_ptr] <= cap_cmd;
      fifo_tag[wr_ptr] <= cap_tag;
      fifo_op1[wr_ptr] <= cap_op1;
      fifo_op2[wr_ptr] <= req_data_in;
    end
  end

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ovf_err <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (ADDR_W+1)'(1);
        2'b01:   count <= count - (ADDR_W+1)'(1);
        default: count <= count;
      endcase
      if (push_req && !dup_hit && fifo_full && !do_pop) ovf_err <= 1'b1;
    end
  end

  // Execute FSM with registered one-cycle response outputs.
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      ex_state <= E_IDLE;
      ex_cmd   <= '0;
      ex_tag   <= '0;
      acc      <= '0;
      ex_op2   <= '0;
      cnt      <= '0;
      out_resp <= '0;
      out_data <= '0;
      out_tag  <= '0;
    end else begin
      out_resp <= 2'b00;
      out_data <= '0;
      out_tag  <= '0;
      case (ex_state)
        E_IDLE: begin
          if (do_pop) begin
            ex_cmd   <= pop_cmd;
            ex_tag   <= fifo_tag[rd_ptr];
            acc      <= fifo_op1[rd_ptr];
            ex_op2   <= pop_op2;
            cnt      <= pop_op2[4:0];
            ex_state <= (pop_cmd == CMD_SHL || pop_cmd == CMD_SHR) ? E_SHIFT : E_ARITH;
          end
        end
        E_ARITH: begin
          out_tag  <= ex_tag;
          ex_state <= E_IDLE;
          case (ex_cmd)
            CMD_ADD: begin
              if (sum[DATA_W]) out_resp <= RESP_ERR;
              else begin
                out_resp <= RESP_OK;
                out_data <= sum[DATA_W-1:0];
              end
            end
            CMD_SUB: begin
              if (ex_op2 > acc) out_resp <= RESP_ERR;
              else begin
                out_resp <= RESP_OK;
                out_data <= acc - ex_op2;
              end
            end
            default: out_resp <= RESP_ERR;
          endcase
        end
        E_SHIFT: begin
          if (cnt == 5'd0) begin
            out_resp <= RESP_OK;
            out_data <= acc;
            out_tag  <= ex_tag;
            ex_state <= E_IDLE;
          end else begin
            acc <= (ex_cmd == CMD_SHL) ? (acc << 1) : (acc >> 1);
            cnt <= cnt - 5'd1;
          end
        end
        default: ex_state <= E_IDLE;
      endcase
    end
  end

endmodule
